psk_demod: RTL and testbench

// - Coherent PSK demodulator: integrates downconverted baseband I/Q over 16-tick symbols,

---
 rtl/psk_demod.sv | 249 ++++++++++++++++++++++++
 tb/tb_psk_demod.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/psk_demod.sv
// Coherent BPSK/QPSK demodulator: integrate-and-dump slicer, byte packer and AXI-Stream output FIFO.
// Optional build macro PSK_DEMOD_STATS_EN adds the lowconf_cnt low-confidence decision counter.
module psk_demod #(
  parameter int WIDTH  = 12,
  parameter int ACC_W  = 16,
  parameter int MARGIN = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_enable,
  input  logic signed [WIDTH-1:0] in_I,
  input  logic signed [WIDTH-1:0] in_Q,
  input  logic                    in_vld,
  input  logic                    in_last,
  input  logic                    in_is_bpsk,
  input  logic [3:0]              SAMPLE_CNT,
  output logic [7:0]              m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    m_tuser,
  output logic                    overflow,
  output logic [1:0]              sym_bits
`ifdef PSK_DEMOD_STATS_EN
  ,
  output logic [15:0]             lowconf_cnt
`endif
);

  if (ACC_W < WIDTH + 4 || MARGIN < 0) begin : g_param_check
    $error("psk_demod: ACC_W must be >= WIDTH+4 and MARGIN non-negative");
  end

  typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

  logic [3:0]              cnt;
  logic signed [ACC_W-1:0] acc_i, acc_q, ext_i, ext_q, sum_i, sum_q;
  logic                    vld_seen, last_seen, vld_now, last_now, dump, decide;
  logic signed [ACC_W:0]   wide_i, wide_q;
  logic [ACC_W:0]          abs_i, abs_q;
  logic [1:0]              slice;

  // The dump tick's own sample is folded in before slicing.
  always_comb begin
    ext_i    = {{(ACC_W-WIDTH){in_I[WIDTH-1]}}, in_I};
    ext_q    = {{(ACC_W-WIDTH){in_Q[WIDTH-1]}}, in_Q};
    sum_i    = acc_i + (in_vld ? ext_i : '0);
    sum_q    = acc_q + (in_vld ? ext_q : '0);
    vld_now  = vld_seen | in_vld;
    last_now = last_seen | (in_vld & in_last);
    dump     = clk_enable && (cnt == SAMPLE_CNT);
    decide   = dump && vld_now;
    wide_i   = {sum_i[ACC_W-1], sum_i};
    wide_q   = {sum_q[ACC_W-1], sum_q};
    abs_i    = wide_i[ACC_W] ? (~wide_i + 1'b1) : wide_i;
    abs_q    = wide_q[ACC_W] ? (~wide_q + 1'b1) : wide_q;
    if (in_is_bpsk)         slice = {2{sum_i[ACC_W-1]}};
    else if (abs_i >= abs_q) slice = sum_i[ACC_W-1] ? 2'b11 : 2'b00;
    else                     slice = sum_q[ACC_W-1] ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      vld_seen  <= 1'b0;
      last_seen <= 1'b0;
    end else if (clk_enable) begin
      cnt <= cnt + 4'd1;
      if (dump) begin
        acc_i     <= '0;
        acc_q     <= '0;
        vld_seen  <= 1'b0;
        last_seen <= 1'b0;
      end else begin
        acc_i     <= sum_i;
        acc_q     <= sum_q;
        vld_seen  <= vld_now;
        last_seen <= last_now;
      end
    end
  end

  logic       dec_vld, dec_bpsk, dec_last;
  logic [1:0] dec_bits;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_vld  <= 1'b0;
      dec_bits <= '0;
      dec_bpsk <= 1'b0;
      dec_last <= 1'b0;
      sym_bits <= '0;
    end else begin
      dec_vld <= decide;
      if (decide) begin
        dec_bits <= slice;
        dec_bpsk <= in_is_bpsk;
        dec_last <= last_now;
        sym_bits <= slice;
      end
    end
  end

  state_t     state, state_n;
  logic [7:0] sr, sr_n, base_sr, placed;
  logic [3:0] nsym, nsym_n, base_n, new_n;
  logic       mode, mode_n, base_mode, full;
  logic [1:0] fl_bits, fl_bits_n, sym_b;
  logic       fl_bpsk, fl_bpsk_n, fl_last, fl_last_n, use_sym, sym_last;
  logic [2:0] qshift, bshift;
  logic       push;
  logic [9:0] push_word;

  // A mode change parks the new symbol in fl_* while the partial byte is emitted;
  // FLUSH then starts a fresh byte from it, so at most one push happens per cycle.
  always_comb begin
    state_n   = state;
    sr_n      = sr;
    nsym_n    = nsym;
    mode_n    = mode;
    fl_bits_n = fl_bits;
    fl_bpsk_n = fl_bpsk;
    fl_last_n = fl_last;
    push      = 1'b0;
    push_word = '0;
    use_sym   = 1'b0;
    sym_b     = dec_bits;
    sym_last  = dec_last;
    base_sr   = sr;
    base_n    = nsym;
    base_mode = mode;
    if (state == FLUSH) begin
      use_sym   = 1'b1;
      sym_b     = fl_bits;
      sym_last  = fl_last;
      base_sr   = '0;
      base_n    = '0;
      base_mode = fl_bpsk;
    end else if (dec_vld) begin
      if (nsym != 4'd0 && dec_bpsk != mode) begin
        push      = 1'b1;
        push_word = {sr, 1'b0, mode};
        sr_n      = '0;
        nsym_n    = '0;
        fl_bits_n = dec_bits;
        fl_bpsk_n = dec_bpsk;
        fl_last_n = dec_last;
        state_n   = FLUSH;
      end else begin
        use_sym = 1'b1;
        if (nsym == 4'd0) begin
          base_sr   = '0;
          base_mode = dec_bpsk;
        end
      end
    end
    qshift = 3'd6 - {base_n[1:0], 1'b0};
    bshift = 3'd7 - base_n[2:0];
    placed = base_mode ? (base_sr | ({7'b0, sym_b[0]} << bshift))
                       : (base_sr | ({6'b0, sym_b} << qshift));
    new_n  = base_n + 4'd1;
    full   = base_mode ? (new_n == 4'd8) : (new_n == 4'd4);
    if (use_sym) begin
      mode_n = base_mode;
      if (full || sym_last) begin
        push      = 1'b1;
        push_word = {placed, sym_last, base_mode};
        sr_n      = '0;
        nsym_n    = '0;
        state_n   = sym_last ? IDLE : PACK;
      end else begin
        sr_n    = placed;
        nsym_n  = new_n;
        state_n = PACK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      nsym    <= '0;
      mode    <= 1'b0;
      fl_bits <= '0;
      fl_bpsk <= 1'b0;
      fl_last <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      nsym    <= nsym_n;
      mode    <= mode_n;
      fl_bits <= fl_bits_n;
      fl_bpsk <= fl_bpsk_n;
      fl_last <= fl_last_n;
    end
  end

  logic [1:0][9:0] fifo_mem;
  logic            wr_ptr, rd_ptr, pop, accept;
  logic [1:0]      count;

  always_comb begin
    m_tvalid                    = (count != 2'd0);
    {m_tdata, m_tlast, m_tuser} = fifo_mem[rd_ptr];
    pop                         = m_tvalid && m_tready;
    accept                      = push && ((count != 2'd2) || pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_mem <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        fifo_mem[wr_ptr] <= push_word;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push && !accept) overflow <= 1'b1;
    end
  end

`ifdef PSK_DEMOD_STATS_EN
  logic [ACC_W:0] abs_diff;
  logic           lowconf;

  always_comb begin
    abs_diff = (abs_i >= abs_q) ? (abs_i - abs_q) : (abs_q - abs_i);
    lowconf  = in_is_bpsk ? (abs_i < (ACC_W+1)'(MARGIN)) : (abs_diff < (ACC_W+1)'(MARGIN));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lowconf_cnt <= '0;
    else if (decide && lowconf && lowconf_cnt != '1) lowconf_cnt <= lowconf_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_psk_demod.sv
// Scoreboard bench for psk_demod: directed symbol sequences, expected bytes queued, monitor pops and compares.
module tb_psk_demod;

  logic              clk = 1'b0;
  logic              rst_n, clk_enable, in_vld, in_last, in_is_bpsk, m_tready;
  logic signed [11:0] in_I, in_Q;
  logic [3:0]        sample_cnt;
  logic [7:0]        m_tdata;
  logic              m_tvalid, m_tlast, m_tuser, overflow;
  logic [1:0]        sym_bits;

  int         total = 0;
  int         bad = 0;
  logic [9:0] sb[$];
  logic [9:0] mon_exp;

  always #5 clk = ~clk;

  psk_demod #(.WIDTH(12), .ACC_W(16), .MARGIN(64)) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .in_I(in_I), .in_Q(in_Q), .in_vld(in_vld), .in_last(in_last),
    .in_is_bpsk(in_is_bpsk), .SAMPLE_CNT(sample_cnt),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .overflow(overflow), .sym_bits(sym_bits)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte format in the queue: {tdata, tlast, tuser}.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %h (tlast=%b tuser=%b) expected none", m_tdata, m_tlast, m_tuser);
      end else begin
        mon_exp = sb.pop_front();
        check("axis_byte", {22'd0, m_tdata, m_tlast, m_tuser}, {22'd0, mon_exp});
      end
    end
  end

  task automatic tick(input logic ce, input logic vld, input int i, input int q,
                      input logic last, input logic bpsk);
    clk_enable = ce;
    in_vld     = vld;
    in_I       = 12'(i);
    in_Q       = 12'(q);
    in_last    = last;
    in_is_bpsk = bpsk;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic sym(input int i, input int q, input logic bpsk, input logic last, input int n = 16);
    repeat (n) tick(1'b1, 1'b1, i, q, last, bpsk);
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic last, input logic user);
    sb.push_back({d, last, user});
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) break;
      idle(1);
    end
    check(name, sb.size(), 0);
    idle(4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    int bp_a[8];
    int bp_b[8];
    bp_a = '{500, -500, -500, 500, 500, 500, -500, 500};
    bp_b = '{-500, 500, 500, 500, 500, 500, 500, -500};
    rst_n      = 1'b0;
    m_tready   = 1'b1;
    sample_cnt = 4'd15;
    idle(2);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast_tuser", {m_tlast, m_tuser}, 0);
    check("rst_overflow", overflow, 0);
    check("rst_sym_bits", sym_bits, 0);
    rst_n = 1'b1;
    idle(1);

    // QPSK 00,01,11,10 with last on the fourth symbol
    expect_byte(8'h1E, 1'b1, 1'b0);
    sym(1000, 0, 1'b0, 1'b0);
    sym(0, 1000, 1'b0, 1'b0);
    sym(-1000, 0, 1'b0, 1'b0);
    sym(0, -1000, 1'b0, 1'b1);
    drain("drain_qpsk");
    check("sym_bits_qpsk", sym_bits, 2'b10);

    // BPSK 0,1,1,0,0,0,1,0
    expect_byte(8'h62, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) sym(bp_a[k], 0, 1'b1, k == 7);
    drain("drain_bpsk");
    check("sym_bits_bpsk", sym_bits, 2'b00);

    // Partial QPSK frame 11,01
    expect_byte(8'hD0, 1'b1, 1'b0);
    sym(-1000, 0, 1'b0, 1'b0);
    sym(0, 1000, 1'b0, 1'b1);
    drain("drain_partial");

    // Mode switch after two QPSK symbols, then a BPSK byte 1000_0001
    expect_byte(8'hD0, 1'b0, 1'b0);
    expect_byte(8'h81, 1'b1, 1'b1);
    sym(-1000, 0, 1'b0, 1'b0);
    sym(0, 1000, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) sym(bp_b[k], 0, 1'b1, k == 7);
    drain("drain_mode_switch");
    check("sym_bits_switch", sym_bits, 2'b11);

    // Back-pressure: 0x55 and 0xFF held, 0xAA dropped
    m_tready = 1'b0;
    expect_byte(8'h55, 1'b0, 1'b0);
    expect_byte(8'hFF, 1'b0, 1'b0);
    repeat (4) sym(0, 1000, 1'b0, 1'b0);
    repeat (4) sym(-1000, 0, 1'b0, 1'b0);
    repeat (4) sym(0, -1000, 1'b0, 1'b0);
    idle(4);
    check("bp_overflow_set", overflow, 1);
    check("bp_tvalid_held", m_tvalid, 1);
    check("bp_tdata_held", m_tdata, 8'h55);
    m_tready = 1'b1;
    drain("drain_backpressure");
    check("bp_overflow_sticky", overflow, 1);
    check("bp_tvalid_empty", m_tvalid, 0);

    // Ties go to the I axis: (+800,+800) -> 00, (-800,-800) -> 11
    expect_byte(8'h30, 1'b1, 1'b0);
    sym(800, 800, 1'b0, 1'b0);
    sym(-800, -800, 1'b0, 1'b1);
    drain("drain_tie");

    // Reset clears overflow; SAMPLE_CNT=7 dumps after 8 ticks
    do_reset();
    check("overflow_after_reset", overflow, 0);
    sample_cnt = 4'd7;
    expect_byte(8'h80, 1'b1, 1'b0);
    sym(0, -1000, 1'b0, 1'b1, 8);
    drain("drain_phase7");
    check("sym_bits_phase7", sym_bits, 2'b10);

    // Reset mid-byte with a byte waiting in the FIFO discards everything
    do_reset();
    sample_cnt = 4'd15;
    m_tready   = 1'b0;
    repeat (4) sym(0, 1000, 1'b0, 1'b0);
    sym(-1000, 0, 1'b0, 1'b0);
    sym(-1000, 0, 1'b0, 1'b0);
    idle(3);
    check("pre_reset_tvalid", m_tvalid, 1);
    rst_n = 1'b0;
    idle(1);
    check("midrst_tvalid", m_tvalid, 0);
    check("midrst_tdata", m_tdata, 0);
    check("midrst_tlast_tuser", {m_tlast, m_tuser}, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_sym_bits", sym_bits, 0);
    rst_n    = 1'b1;
    m_tready = 1'b1;
    idle(1);
    expect_byte(8'h40, 1'b1, 1'b0);
    sym(0, 1000, 1'b0, 1'b1);
    drain("drain_after_reset");
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
